// File: rtl/cp0_exc_responder.sv
// Coprocessor-0 responder: takes exceptions/interrupts reported at MEM/W, keeps SR/Cause/EPC,
// drives the pipeline flush and handler/return PCs, and serves mtc0/mfc0.
module cp0_exc_responder #(
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] PRID_VAL   = 32'h0000_7C07,
    parameter logic [4:0]  NEXC_CODE  = 5'b11111
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ExcCode_MEM,
    input  logic [31:0] PC_EPC,
    input  logic        Delay_Set,
    input  logic        EXLClr,
    input  logic [5:0]  HWInt,
    input  logic [4:0]  CP0_RW_Addr,
    input  logic        CP0_WE,
    input  logic [31:0] CP0_WData,
    output logic [31:0] CP0_RData,
    output logic        EXC_flush,
    output logic [31:0] Handler_PC,
    output logic [31:0] EPC_Out,
    output logic        In_Handler
);

    localparam logic [4:0] AddrSr    = 5'd12;
    localparam logic [4:0] AddrCause = 5'd13;
    localparam logic [4:0] AddrEpc   = 5'd14;
    localparam logic [4:0] AddrPrid  = 5'd15;

    // The handler state is SR.EXL itself.
    typedef enum logic [0:0] {
        StRun     = 1'b0,
        StHandler = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [5:0]  sr_im_q, sr_im_d;
    logic        sr_ie_q, sr_ie_d;
    logic        cause_bd_q, cause_bd_d;
    logic [5:0]  cause_ip_q, cause_ip_d;
    logic [4:0]  cause_exc_q, cause_exc_d;
    logic [31:2] epc_q, epc_d;

    logic        exl;
    logic        int_req;
    logic        exc_req;
    logic        take;
    logic        mtc0_en;
    logic [31:0] sr_word;
    logic [31:0] cause_word;
    logic [31:0] epc_word;
    logic        unused_pc;

    assign unused_pc = ^PC_EPC[1:0];

    assign exl     = (state_q == StHandler);
    assign int_req = (|(HWInt & sr_im_q)) & sr_ie_q & ~exl;
    assign exc_req = (ExcCode_MEM != NEXC_CODE) & ~exl;
    assign take    = (int_req | exc_req) & ~reset;
    // A take kills the faulting instruction, so its mtc0 must not retire.
    assign mtc0_en = CP0_WE & ~take;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: take > eret > mtc0 write of SR.EXL
    always_comb begin
        state_d = state_q;
        if (take) begin
            state_d = StHandler;
        end else if (EXLClr) begin
            state_d = StRun;
        end else if (mtc0_en && (CP0_RW_Addr == AddrSr)) begin
            state_d = CP0_WData[1] ? StHandler : StRun;
        end
    end

    // Outputs
    always_comb begin
        EXC_flush  = take;
        In_Handler = exl;
        Handler_PC = HANDLER_PC;
        EPC_Out    = epc_word;
    end

    always_comb begin
        sr_im_d     = sr_im_q;
        sr_ie_d     = sr_ie_q;
        cause_bd_d  = cause_bd_q;
        cause_ip_d  = HWInt;
        cause_exc_d = cause_exc_q;
        epc_d       = epc_q;
        if (take) begin
            cause_bd_d  = Delay_Set;
            epc_d       = PC_EPC[31:2];
            cause_exc_d = int_req ? 5'b00000 : ExcCode_MEM;
        end else if (mtc0_en) begin
            if (CP0_RW_Addr == AddrSr) begin
                sr_im_d = CP0_WData[15:10];
                sr_ie_d = CP0_WData[0];
            end else if (CP0_RW_Addr == AddrEpc) begin
                epc_d = CP0_WData[31:2];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im_q     <= '0;
            sr_ie_q     <= 1'b0;
            cause_bd_q  <= 1'b0;
            cause_ip_q  <= '0;
            cause_exc_q <= '0;
            epc_q       <= '0;
        end else begin
            sr_im_q     <= sr_im_d;
            sr_ie_q     <= sr_ie_d;
            cause_bd_q  <= cause_bd_d;
            cause_ip_q  <= cause_ip_d;
            cause_exc_q <= cause_exc_d;
            epc_q       <= epc_d;
        end
    end

    assign sr_word    = {16'h0, sr_im_q, 8'h0, exl, sr_ie_q};
    assign cause_word = {cause_bd_q, 15'h0, cause_ip_q, 3'h0, cause_exc_q, 2'b00};
    assign epc_word   = {epc_q, 2'b00};

    // mfc0 reads registered state only, so a same-cycle mtc0 is not visible.
    always_comb begin
        CP0_RData = 32'h0;
        case (CP0_RW_Addr)
            AddrSr:    CP0_RData = sr_word;
            AddrCause: CP0_RData = cause_word;
            AddrEpc:   CP0_RData = epc_word;
            AddrPrid:  CP0_RData = PRID_VAL;
            default:   CP0_RData = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_cp0_exc_responder.sv
// Directed bench for cp0_exc_responder: hand-computed SR/Cause/EPC and flush expectations.
module tb_cp0_exc_responder;

    logic        clk;
    logic        reset;
    logic [4:0]  ExcCode_MEM;
    logic [31:0] PC_EPC;
    logic        Delay_Set;
    logic        EXLClr;
    logic [5:0]  HWInt;
    logic [4:0]  CP0_RW_Addr;
    logic        CP0_WE;
    logic [31:0] CP0_WData;
    logic [31:0] CP0_RData;
    logic        EXC_flush;
    logic [31:0] Handler_PC;
    logic [31:0] EPC_Out;
    logic        In_Handler;

    int errors = 0;
    int checks = 0;

    cp0_exc_responder dut (
        .clk         (clk),
        .reset       (reset),
        .ExcCode_MEM (ExcCode_MEM),
        .PC_EPC      (PC_EPC),
        .Delay_Set   (Delay_Set),
        .EXLClr      (EXLClr),
        .HWInt       (HWInt),
        .CP0_RW_Addr (CP0_RW_Addr),
        .CP0_WE      (CP0_WE),
        .CP0_WData   (CP0_WData),
        .CP0_RData   (CP0_RData),
        .EXC_flush   (EXC_flush),
        .Handler_PC  (Handler_PC),
        .EPC_Out     (EPC_Out),
        .In_Handler  (In_Handler)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        CP0_RW_Addr = addr;
        #1;
        check(tag, CP0_RData, exp);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        CP0_RW_Addr = addr;
        CP0_WData   = data;
        CP0_WE      = 1'b1;
        step();
        CP0_WE      = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        ExcCode_MEM = 5'b11111;
        PC_EPC      = 32'h0;
        Delay_Set   = 1'b0;
        EXLClr      = 1'b0;
        HWInt       = 6'b0;
        CP0_RW_Addr = 5'd0;
        CP0_WE      = 1'b0;
        CP0_WData   = 32'h0;
        step();
        step();
        reset = 1'b0;
        settle();
        check("rst_flush", {31'h0, EXC_flush}, 32'h0);
        check("rst_inh", {31'h0, In_Handler}, 32'h0);
        check("rst_epc_out", EPC_Out, 32'h0);
        check("rst_handler_pc", Handler_PC, 32'h0000_4180);
        rd("rst_sr", 5'd12, 32'h0);
        rd("rst_cause", 5'd13, 32'h0);
        rd("rst_prid", 5'd15, 32'h0000_7C07);

        // AdEL
        ExcCode_MEM = 5'b00100;
        PC_EPC      = 32'h0000_3008;
        settle();
        check("adel_flush", {31'h0, EXC_flush}, 32'h1);
        step();
        ExcCode_MEM = 5'b11111;
        settle();
        check("adel_flush_after", {31'h0, EXC_flush}, 32'h0);
        check("adel_inh", {31'h0, In_Handler}, 32'h1);
        rd("adel_cause", 5'd13, 32'h0000_0010);
        rd("adel_epc", 5'd14, 32'h0000_3008);
        rd("adel_sr", 5'd12, 32'h0000_0002);
        EXLClr = 1'b1;
        step();
        EXLClr = 1'b0;
        settle();
        check("eret_inh", {31'h0, In_Handler}, 32'h0);

        // Stray eret keeps EXL clear
        EXLClr = 1'b1;
        step();
        EXLClr = 1'b0;
        settle();
        check("stray_eret_inh", {31'h0, In_Handler}, 32'h0);

        // Delay-slot overflow
        ExcCode_MEM = 5'b01100;
        Delay_Set   = 1'b1;
        PC_EPC      = 32'h0000_3010;
        step();
        ExcCode_MEM = 5'b11111;
        Delay_Set   = 1'b0;
        rd("ov_cause", 5'd13, 32'h8000_0030);
        check("ov_epc_out", EPC_Out, 32'h0000_3010);
        EXLClr = 1'b1;
        step();
        EXLClr = 1'b0;

        // Interrupt, IE=1
        mtc0(5'd12, 32'h0000_0401);
        rd("int_sr", 5'd12, 32'h0000_0401);
        HWInt = 6'b000001;
        settle();
        check("int_flush", {31'h0, EXC_flush}, 32'h1);
        step();
        rd("int_cause", 5'd13, 32'h0000_0400);
        check("int_inh", {31'h0, In_Handler}, 32'h1);
        check("int_no_retake", {31'h0, EXC_flush}, 32'h0);
        HWInt  = 6'b0;
        EXLClr = 1'b1;
        step();
        EXLClr = 1'b0;

        // Interrupt, IE=0: no take, IP still tracks the line
        mtc0(5'd12, 32'h0000_0400);
        HWInt = 6'b000001;
        settle();
        check("noie_flush", {31'h0, EXC_flush}, 32'h0);
        step();
        rd("noie_cause", 5'd13, 32'h0000_0400);
        check("noie_inh", {31'h0, In_Handler}, 32'h0);
        HWInt = 6'b0;

        // Simultaneous interrupt + RI, same-cycle mtc0 EPC dropped
        mtc0(5'd12, 32'h0000_FC01);
        HWInt       = 6'b000100;
        ExcCode_MEM = 5'b01010;
        PC_EPC      = 32'h0000_3040;
        CP0_RW_Addr = 5'd14;
        CP0_WData   = 32'h0000_5554;
        CP0_WE      = 1'b1;
        settle();
        check("sim_flush", {31'h0, EXC_flush}, 32'h1);
        step();
        CP0_WE      = 1'b0;
        HWInt       = 6'b0;
        ExcCode_MEM = 5'b11111;
        rd("sim_cause", 5'd13, 32'h0000_1000);
        rd("sim_epc", 5'd14, 32'h0000_3040);

        // mtc0 EPC in handler: old value readable same cycle, low bits forced
        CP0_RW_Addr = 5'd14;
        CP0_WData   = 32'h0000_3023;
        CP0_WE      = 1'b1;
        settle();
        check("epc_same_cycle", CP0_RData, 32'h0000_3040);
        step();
        CP0_WE = 1'b0;
        rd("epc_written", 5'd14, 32'h0000_3020);
        mtc0(5'd13, 32'hFFFF_FFFF);
        rd("cause_ro", 5'd13, 32'h0000_1000 & 32'h0);

        // Handler exit with RI pending
        ExcCode_MEM = 5'b01010;
        PC_EPC      = 32'h0000_3020;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("exl_mask_flush", {31'h0, EXC_flush}, 32'h0);
            step();
        end
        EXLClr = 1'b1;
        step();
        EXLClr = 1'b0;
        settle();
        check("exit_inh", {31'h0, In_Handler}, 32'h0);
        check("exit_flush", {31'h0, EXC_flush}, 32'h1);
        step();
        ExcCode_MEM = 5'b11111;
        settle();
        check("ri_inh", {31'h0, In_Handler}, 32'h1);
        rd("ri_cause", 5'd13, 32'h0000_0028);
        check("ri_epc_out", EPC_Out, 32'h0000_3020);

        // Reset in handler
        reset = 1'b1;
        step();
        reset = 1'b0;
        rd("rst2_sr", 5'd12, 32'h0);
        rd("rst2_epc", 5'd14, 32'h0);
        check("rst2_inh", {31'h0, In_Handler}, 32'h0);
        rd("rst2_prid", 5'd15, 32'h0000_7C07);
        rd("rst2_addr7", 5'd7, 32'h0);

        // Pending exception during reset is not taken
        reset       = 1'b1;
        ExcCode_MEM = 5'b00100;
        settle();
        check("rst_blocks_flush", {31'h0, EXC_flush}, 32'h0);
        step();
        reset       = 1'b0;
        ExcCode_MEM = 5'b11111;
        settle();
        check("rst_no_take", {31'h0, In_Handler}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cp0_exc_responder.md
# cp0_exc_responder

Coprocessor-0 responder for the pipelined MIPS core. It consumes the exception/interrupt stream that the pipeline's exception-detection logic delivers at the MEM/W boundary: ExcCode, victim PC, branch-delay flag and eret-reached-W. It decides whether to take an exception or interrupt, and records SR, Cause and EPC state. It drives the global flush and the handler/return PCs back to the fetch stage, and serves mtc0/mfc0 accesses.

## Interface
Parameters:
- HANDLER_PC, 32'h0000_4180, exception vector driven on Handler_PC
- PRID_VAL, 32'h0000_7C07, constant returned for register 15
- NEXC_CODE, 5'b11111, ExcCode value meaning "no exception"

Ports:
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high; sampled on rising clk
- ExcCode_MEM  in  5  exception code of instruction at MEM/W; NEXC_CODE = none
- PC_EPC  in  32  victim PC; already the branch PC when Delay_Set=1
- Delay_Set  in  1  victim sits in a branch delay slot
- EXLClr  in  1  eret has reached W; clear EXL
- HWInt  in  6  external interrupt lines, level-sensitive
- CP0_RW_Addr  in  5  mtc0/mfc0 register number
- CP0_WE  in  1  mtc0 write enable at MEM/W
- CP0_WData  in  32  mtc0 write data
- CP0_RData  out  32  mfc0 read data, combinational
- EXC_flush  out  1  take exception/interrupt now; flush pipeline, fetch Handler_PC
- Handler_PC  out  32  constant HANDLER_PC
- EPC_Out  out  32  current EPC, the eret target
- In_Handler  out  1  mirrors SR.EXL

## Operation
- Registers:
  - SR (12): IM[15:10], EXL[1], IE[0]; all other bits read as 0.
  - Cause (13): BD[31], IP[15:10], ExcCode[6:2]; other bits 0.
  - EPC (14): 32 bits, bits [1:0] forced to 0.
  - PRId (15): PRID_VAL.
  - Any other address reads 32'h0.
- State machine, 2 states encoded by SR.EXL:
  - RUN (EXL=0) -> HANDLER on a take edge.
  - HANDLER -> RUN on an EXLClr edge.
- IntReq = |(HWInt & SR.IM) & SR.IE & !SR.EXL.
- ExcReq = (ExcCode_MEM != NEXC_CODE) & !SR.EXL.
- EXC_flush = (IntReq | ExcReq) & !reset, combinational.
- Take edge (EXC_flush=1 at rising clk):
  - EXL <= 1.
  - BD <= Delay_Set.
  - EPC <= {PC_EPC[31:2],2'b00}.
  - Cause.ExcCode <= IntReq ? 5'b00000 : ExcCode_MEM. Interrupt has priority over a simultaneous exception.
- Cause.IP <= HWInt on every non-reset edge, independent of masks.
- EXLClr edge: EXL <= 0. It has no effect on other fields.
- mtc0 edge (CP0_WE=1, EXC_flush=0):
  - addr 12 writes IM/EXL/IE from CP0_WData.
  - addr 14 writes EPC with [1:0] forced to 0.
  - addr 13, 15 and others are ignored; Cause and PRId are read-only.
- Priority within one edge: reset > take > EXLClr > mtc0. A take suppresses the mtc0 of the same cycle, because the faulting instruction does not retire.
- EXLClr while EXL=0 (stray eret) is harmless: EXL stays 0.
- Exceptions that arrive while EXL=1 are ignored, with no nesting.
- HWInt changes while EXL=1 still update IP but do not trigger a take.

## Timing
- Reset values: SR=0, Cause=0, EPC=0. So EXC_flush=0, In_Handler=0, EPC_Out=0, CP0_RData=0 for addr≠15, Handler_PC=HANDLER_PC.
- Reset asserted mid-handler returns the block to RUN on that edge, with no take recorded.
- EXC_flush is combinational with 0-cycle latency from ExcCode_MEM/HWInt/SR. It stays high until the take edge sets EXL, so it is exactly one cycle wide for a single event.
- Register updates become visible the cycle after the edge.
- mfc0 in the same cycle as an mtc0 to the same register returns the old value, with no internal bypass.
- EPC_Out reflects a new EPC starting the cycle after the take edge.

## Test plan
- Reset then AdEL:
  - Stimulus: reset 2 cycles; ExcCode_MEM=5'b00100, PC_EPC=32'h0000_3008, Delay_Set=0 for 1 cycle.
  - Response: EXC_flush=1 that cycle. Next cycle Cause=32'h0000_0010, EPC=32'h0000_3008, SR.EXL=1, EXC_flush=0.
- Delay-slot overflow:
  - Stimulus: ExcCode_MEM=5'b01100, Delay_Set=1, PC_EPC=32'h0000_3010.
  - Response: Cause=32'h8000_0030, EPC_Out=32'h0000_3010.
- Interrupt gating:
  - Stimulus: mtc0 SR=32'h0000_0401, then HWInt=6'b000001.
  - Response: EXC_flush=1; next cycle Cause.ExcCode=0, IP=6'b000001.
  - Repeat with IE=0: EXC_flush stays 0, and IP still shows 1.
- Simultaneous interrupt and RI with SR=32'h0000_FC01:
  - Response: Cause.ExcCode=0 (interrupt wins). The same-cycle mtc0 to EPC is dropped.
- Handler exit:
  - Stimulus: EXL=1, ExcCode_MEM=5'b01010 held 3 cycles; then EXLClr=1 for 1 cycle.
  - Response: no flush while EXL=1. After the EXLClr edge, In_Handler=0, and the still-present RI flushes in the following cycle.
- Reset in handler:
  - Stimulus: EXL=1, EPC=32'h0000_3020, reset 1 cycle.
  - Response: SR=0, EPC=0, In_Handler=0.
  - mfc0 addr 15 returns 32'h0000_7C07; addr 7 returns 0.
